// File: rtl/lcd_pkg.sv
// Shared constants, FSM encoding and helpers for the multi-field LCD1602 controller.
package lcd_pkg;

    localparam logic [7:0] LCD_CMD_FUNCSET = 8'h38;
    localparam logic [7:0] LCD_CMD_ENTRY   = 8'h06;
    localparam logic [7:0] LCD_CMD_DISPON  = 8'h0C;
    localparam logic [7:0] LCD_CMD_CLEAR   = 8'h01;
    localparam logic [7:0] LCD_CMD_LINE2   = 8'hC0;

    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_ZERO  = 8'h30;
    localparam logic [7:0] ASCII_OVF   = 8'h2A;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_CONV,
        S_CURSOR,
        S_DATA,
        S_NEXT
    } state_t;

    // ceil(w * log10(2)) in integer arithmetic
    function automatic int bcd_digits(input int w);
        return (w * 30103 + 99999) / 100000;
    endfunction

    function automatic logic [7:0] init_cmd(input logic [1:0] i);
        case (i)
            2'd0:    return LCD_CMD_FUNCSET;
            2'd1:    return LCD_CMD_ENTRY;
            2'd2:    return LCD_CMD_DISPON;
            default: return LCD_CMD_CLEAR;
        endcase
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one add-3 cycle and one shift cycle per input bit.
module bin2bcd_seq #(
    parameter int BIN_WIDTH = 16,
    parameter int BCD_D     = 5
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start_i,
    input  logic [BIN_WIDTH-1:0]   bin_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic [4*BCD_D-1:0]     bcd_o
);

    localparam int CW = $clog2(BIN_WIDTH + 1);

    logic [BIN_WIDTH-1:0] sh;
    logic [CW-1:0]        cnt;
    logic                 shift_phase;

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            bcd_o       <= '0;
            sh          <= '0;
            cnt         <= '0;
            shift_phase <= 1'b0;
        end else begin
            done_o <= 1'b0;
            if (!busy_o) begin
                if (start_i) begin
                    busy_o      <= 1'b1;
                    sh          <= bin_i;
                    bcd_o       <= '0;
                    cnt         <= '0;
                    shift_phase <= 1'b0;
                end
            end else if (!shift_phase) begin
                for (int unsigned i = 0; i < BCD_D; i++) begin
                    if (bcd_o[4*i +: 4] >= 4'd5)
                        bcd_o[4*i +: 4] <= bcd_o[4*i +: 4] + 4'd3;
                end
                shift_phase <= 1'b1;
            end else begin
                {bcd_o, sh} <= {bcd_o[4*BCD_D-2:0], sh, 1'b0};
                shift_phase <= 1'b0;
                cnt         <= cnt + 1'b1;
                if (cnt == CW'(BIN_WIDTH - 1)) begin
                    busy_o <= 1'b0;
                    done_o <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/lcd1602_multifield_ctrl.sv
// HD44780 8-bit driver: power-up commands, then round-robin refresh of numeric fields
// rendered as right-aligned ASCII decimal.
module lcd1602_multifield_ctrl
    import lcd_pkg::*;
#(
    parameter int                      NUM_FIELDS  = 2,
    parameter int                      BIN_WIDTH   = 16,
    parameter int                      NUM_DIGITS  = 5,
    parameter int                      SLOT_CYCLES = 800000,
    parameter logic [NUM_FIELDS*8-1:0] FIELD_ADDR  = {8'hCB, 8'h8B},
    parameter bit                      BLANK_ZEROS = 1'b1,
    parameter bit                      SKIP_UNCHGD = 1'b0
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             ready_i,
    input  logic [NUM_FIELDS*BIN_WIDTH-1:0]  values_i,
    output logic                             rs,
    output logic                             rw,
    output logic                             enable,
    output logic [7:0]                       data,
    output logic                             busy_o,
    output logic                             frame_done_o
);

    localparam int BCD_D = bcd_digits(BIN_WIDTH);
    localparam int MAXD  = (BCD_D > NUM_DIGITS) ? BCD_D : NUM_DIGITS;
    localparam int MAXS  = (NUM_DIGITS > 4) ? NUM_DIGITS : 4;
    localparam int IW    = $clog2(MAXS);
    localparam int SCW   = $clog2(SLOT_CYCLES);
    localparam int KW    = (NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1;

    state_t               state, state_next;
    logic [SCW-1:0]       slot_cnt;
    logic [IW-1:0]        idx;
    logic [KW-1:0]        k;
    logic                 busy_q;
    logic                 conv_started;
    logic [BIN_WIDTH-1:0] snap;
    logic [BIN_WIDTH-1:0] cur_value;
    logic [BIN_WIDTH-1:0] last_val [NUM_FIELDS];
    logic [7:0]           chars [NUM_DIGITS];
    logic [7:0]           fmt [NUM_DIGITS];

    logic                 cv_start, cv_busy, cv_done;
    logic [4*BCD_D-1:0]   cv_bcd;
    logic [4*MAXD-1:0]    bcd_pad;

    logic slot_last, k_last, slotted, en_win, skip;

    assign slot_last = (slot_cnt == SCW'(SLOT_CYCLES - 1));
    assign k_last    = (k == KW'(NUM_FIELDS - 1));
    assign slotted   = (state == S_INIT) || (state == S_CURSOR) || (state == S_DATA);
    assign en_win    = (slot_cnt >= SCW'(SLOT_CYCLES / 4)) && (slot_cnt < SCW'(SLOT_CYCLES / 2));
    assign cur_value = values_i[BIN_WIDTH*int'(k) +: BIN_WIDTH];
    assign skip      = SKIP_UNCHGD && (snap == last_val[k]);
    assign cv_start  = (state == S_CONV) && !conv_started && !cv_busy;
    assign rw        = 1'b0;
    assign busy_o    = busy_q;

    bin2bcd_seq #(
        .BIN_WIDTH (BIN_WIDTH),
        .BCD_D     (BCD_D)
    ) u_bcd (
        .clk     (clk),
        .reset   (reset),
        .start_i (cv_start),
        .bin_i   (cur_value),
        .busy_o  (cv_busy),
        .done_o  (cv_done),
        .bcd_o   (cv_bcd)
    );

    // Formatter: chars[0] is the most significant position on the display
    always_comb begin
        logic       ovf;
        logic       lead;
        logic [3:0] dig;
        bcd_pad = (4*MAXD)'(cv_bcd);
        ovf     = 1'b0;
        lead    = 1'b1;
        dig     = '0;
        for (int unsigned i = NUM_DIGITS; i < MAXD; i++) begin
            if (bcd_pad[4*i +: 4] != 4'd0) ovf = 1'b1;
        end
        for (int unsigned j = 0; j < NUM_DIGITS; j++) begin
            dig = bcd_pad[4*(NUM_DIGITS-1-j) +: 4];
            if (ovf) begin
                fmt[j] = ASCII_OVF;
            end else if (BLANK_ZEROS && lead && dig == 4'd0 && j != NUM_DIGITS - 1) begin
                fmt[j] = ASCII_SPACE;
            end else begin
                fmt[j] = ASCII_ZERO + {4'h0, dig};
                lead   = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next   = state;
        rs           = 1'b0;
        enable       = 1'b0;
        data         = '0;
        frame_done_o = 1'b0;
        case (state)
            S_IDLE: begin
                if (ready_i) state_next = S_INIT;
            end
            S_INIT: begin
                data   = init_cmd(idx[1:0]);
                enable = en_win;
                if (slot_last && idx == IW'(3)) state_next = S_CONV;
            end
            S_CONV: begin
                if (cv_done) state_next = skip ? S_NEXT : S_CURSOR;
            end
            S_CURSOR: begin
                data   = FIELD_ADDR[8*int'(k) +: 8];
                enable = en_win;
                if (slot_last) state_next = S_DATA;
            end
            S_DATA: begin
                rs     = 1'b1;
                enable = en_win;
                for (int unsigned j = 0; j < NUM_DIGITS; j++) begin
                    if (idx == IW'(j)) data = chars[j];
                end
                if (slot_last && idx == IW'(NUM_DIGITS - 1)) state_next = S_NEXT;
            end
            S_NEXT: begin
                frame_done_o = k_last;
                state_next   = S_CONV;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            slot_cnt     <= '0;
            idx          <= '0;
            k            <= '0;
            busy_q       <= 1'b0;
            conv_started <= 1'b0;
            snap         <= '0;
            for (int unsigned f = 0; f < NUM_FIELDS; f++) last_val[f] <= '0;
            for (int unsigned j = 0; j < NUM_DIGITS; j++) chars[j] <= '0;
        end else begin
            if (state == S_IDLE && ready_i) busy_q <= 1'b1;

            if (slotted) begin
                if (slot_last) begin
                    slot_cnt <= '0;
                    idx      <= (state_next == state) ? idx + 1'b1 : '0;
                end else begin
                    slot_cnt <= slot_cnt + 1'b1;
                end
            end else begin
                slot_cnt <= '0;
                idx      <= '0;
            end

            // Exactly one conversion per S_CONV visit, even if the converter goes idle early
            conv_started <= (state == S_CONV) && !cv_done && (conv_started || cv_start);
            if (cv_start) snap <= cur_value;

            if (state == S_CONV && cv_done) begin
                for (int unsigned j = 0; j < NUM_DIGITS; j++) chars[j] <= fmt[j];
            end
            if (state == S_DATA && state_next == S_NEXT) last_val[k] <= snap;
            if (state == S_NEXT) k <= k_last ? '0 : k + 1'b1;
        end
    end

endmodule
